gpio_ctrl: RTL and testbench
============================

# gpio_ctrl

Parametrised general-purpose I/O controller for the peripheral bus. It provides per-pin direction, atomic set/clear/toggle output access and a multi-stage input synchronizer. Each pin has configurable interrupt detection (edge or level, either polarity) with sticky write-1-to-clear status. It sits on the core data-bus slave port alongside the other memory-mapped peripherals and drives one combined interrupt line to the interrupt controller.

## Interface
- ADDR_WIDTH, 12, width of data_addr_i (byte address; bits [1:0] ignored)
- N_GPIO, 16, number of pins, legal range 1..32
- SYNC_STAGES, 2, input synchronizer depth, legal range 2..4
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
- en_i  in  1  peripheral select from address decoder
- data_req_i  in  1  bus request
- data_gnt_o  out  1  grant
- data_rvalid_o  out  1  response valid
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  ADDR_WIDTH  register byte address
- data_wdata_i  in  32  write data
- data_rdata_o  out  32  read data
- gpio_i  in  N_GPIO  asynchronous pin inputs
- gpio_o  out  N_GPIO  pin output values
- gpio_oe_o  out  N_GPIO  pin output enables (1 = drive)
- irq_o  out  1  combined interrupt

## Operation
- Register map (byte offsets):
  - 0x00 DIR: RW.
  - 0x04 OUT: RW.
  - 0x08 IN: RO, synchronized inputs.
  - 0x0C OUT_SET, 0x10 OUT_CLR, 0x14 OUT_TGL: WO, read 0.
  - 0x18 IE: RW.
  - 0x1C ITYPE: RW, 1 = edge, 0 = level.
  - 0x20 IPOL: RW, 1 = rising/high, 0 = falling/low.
  - 0x24 ISTAT: read; write 1 to clear.
  - Other offsets read 0 and ignore writes.
- Bits [31:N_GPIO] of every register read 0 and ignore writes.
- A write occurs when en_i & data_req_i & data_we_i. Only byte lanes with data_be_i set are affected. This applies to RW registers and to the SET/CLR/TGL/W1C masks.
- OUT_SET: OUT |= m. OUT_CLR: OUT &= ~m. OUT_TGL: OUT ^= m. Here m is wdata masked by the byte enables.
- gpio_o = OUT, gpio_oe_o = DIR. OUT is independent of DIR.
- Input path: gpio_i goes through an SYNC_STAGES flop chain to s, then through one more flop to s_d.
- Rise event = s & ~s_d; fall event = ~s & s_d.
- Per pin, the event source is:
  - ITYPE=1: IPOL ? rise : fall.
  - ITYPE=0: IPOL ? s : ~s, asserted every cycle the condition holds.
- ISTAT bit is set on an event regardless of IE. It stays set until cleared by a W1C write.
- Simultaneous event and W1C on the same bit: the set wins. A level source that is still active therefore re-sets the bit.
- irq_o = |(ISTAT & IE), combinational from registers.

## Timing
- data_gnt_o = data_req_i & en_i, combinational, same cycle as the request.
- data_rvalid_o is registered: high exactly one cycle after each granted request, reads and writes alike.
- data_rdata_o is registered, sampled at the grant edge, and valid while data_rvalid_o is high.
  - It holds its previous value when there is no read.
  - It returns register contents from before any update at that same edge.
- Written values are visible on outputs and registers the cycle after the write edge.
- Input latency: a gpio_i change stable before edge 1 reaches IN after edge SYNC_STAGES. The edge event sets ISTAT at edge SYNC_STAGES+1. irq_o rises in the same cycle if IE is set (edges 2 and 3 for the default).
- Pulses shorter than one clock may be missed. No debouncing is performed.
- Reset values: all registers 0, the sync chain and s_d 0, data_rdata_o 0, data_rvalid_o 0, gpio_o 0, gpio_oe_o 0, irq_o 0.
- A pin held high through reset release produces one rise event once the chain fills.
- Reset asserted mid-transaction clears data_rvalid_o immediately and drops the pending response.

## Test plan
- Reset, then read every offset -> all return 0. gpio_oe_o=0, gpio_o=0, irq_o=0.
- Write DIR=0x00FF, OUT=0x1234; OUT_SET 0x0001; OUT_CLR 0x0200; OUT_TGL 0x8000 -> gpio_o=0x9035, gpio_oe_o=0x00FF. Each rvalid arrives one cycle after its grant.
- Write OUT=0xFFFF with data_be_i=4'b0001 starting from OUT=0 -> OUT=0x00FF. Write 0xFFFFFFFF to DIR with N_GPIO=16 -> readback 0x0000FFFF.
- IE=1, ITYPE=1, IPOL=1; raise gpio_i[0] before edge 1 -> IN[0]=1 after edge 2, ISTAT=1 and irq_o=1 after edge 3. W1C 0x1 -> irq_o=0 next cycle. A falling edge causes no set.
- Level-low on pin 3 (ITYPE=0, IPOL=0, IE=0x8) with gpio_i[3]=0 -> W1C of 0x8 is overridden and ISTAT stays 0x8. Release the pin, then W1C -> ISTAT=0 and irq_o=0.
- Rising event on pin 5 in the same cycle as a W1C of bit 5 -> ISTAT[5] remains 1.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl -- memory-mapped general-purpose I/O controller.
//
// Provides per-pin direction, output value with atomic set/clear/toggle
// access, a multi-stage input synchronizer and per-pin interrupt detection.
// Detection is either edge or level, with either polarity. Status bits are
// sticky and cleared by writing 1.
//
// Ports:
//   clk_i, rstn_i     clock, asynchronous active-low reset
//   en_i              peripheral select from the address decoder
//   data_req_i        bus request; data_gnt_o = data_req_i & en_i (combinational)
//   data_we_i         1 = write
//   data_be_i         byte enables
//   data_addr_i       byte address; bits [1:0] are ignored
//   data_wdata_i      write data
//   data_rvalid_o     response valid, one cycle after every grant
//   data_rdata_o      registered read data; holds its value when there is no read
//   gpio_i            asynchronous pin inputs
//   gpio_o, gpio_oe_o pin output values and output enables (1 = drive)
//   irq_o             |(ISTAT & IE)
module gpio_ctrl #(
   parameter int ADDR_WIDTH  = 12,
   parameter int N_GPIO      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  en_i,
   input  logic                  data_req_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [31:0]           data_wdata_i,
   output logic [31:0]           data_rdata_o,
   input  logic [N_GPIO-1:0]     gpio_i,
   output logic [N_GPIO-1:0]     gpio_o,
   output logic [N_GPIO-1:0]     gpio_oe_o,
   output logic                  irq_o
);

   localparam int OW = ADDR_WIDTH - 2;
   localparam logic [OW-1:0] OFF_DIR   = OW'(0);
   localparam logic [OW-1:0] OFF_OUT   = OW'(1);
   localparam logic [OW-1:0] OFF_IN    = OW'(2);
   localparam logic [OW-1:0] OFF_SET   = OW'(3);
   localparam logic [OW-1:0] OFF_CLR   = OW'(4);
   localparam logic [OW-1:0] OFF_TGL   = OW'(5);
   localparam logic [OW-1:0] OFF_IE    = OW'(6);
   localparam logic [OW-1:0] OFF_ITYPE = OW'(7);
   localparam logic [OW-1:0] OFF_IPOL  = OW'(8);
   localparam logic [OW-1:0] OFF_ISTAT = OW'(9);

   logic              gnt, wr, rd;
   logic [OW-1:0]     woff;
   logic [31:0]       be_mask;
   logic [N_GPIO-1:0] bm, wm;

   logic [N_GPIO-1:0] dir_q, out_q, ie_q, itype_q, ipol_q, istat_q;
   logic [N_GPIO-1:0] out_d, w1c;
   logic [SYNC_STAGES-1:0][N_GPIO-1:0] sync_q;
   logic [N_GPIO-1:0] s, s_d, rise, fall, ev;
   logic [31:0]       rd_mux;
   logic              rvalid_q;
   logic [31:0]       rdata_q;

   assign gnt  = data_req_i & en_i;
   assign wr   = gnt & data_we_i;
   assign rd   = gnt & ~data_we_i;
   assign woff = data_addr_i[ADDR_WIDTH-1:2];

   always_comb begin
      be_mask = '0;
      for (int b = 0; b < 4; b++) be_mask[8*b +: 8] = {8{data_be_i[b]}};
   end

   // bm selects the bits a write may touch; wm is the byte-masked write data,
   // used both as a new RW value and as the SET/CLR/TGL/W1C mask.
   assign bm = be_mask[N_GPIO-1:0];
   assign wm = data_wdata_i[N_GPIO-1:0] & bm;

   // ---------------- output register with atomic access ----------------
   always_comb begin
      out_d = out_q;
      if (wr) begin
         case (woff)
            OFF_OUT: out_d = (out_q & ~bm) | wm;
            OFF_SET: out_d = out_q | wm;
            OFF_CLR: out_d = out_q & ~wm;
            OFF_TGL: out_d = out_q ^ wm;
            default: out_d = out_q;
         endcase
      end
   end

   assign w1c = (wr && woff == OFF_ISTAT) ? wm : '0;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         dir_q   <= '0;
         out_q   <= '0;
         ie_q    <= '0;
         itype_q <= '0;
         ipol_q  <= '0;
      end else begin
         out_q <= out_d;
         if (wr && woff == OFF_DIR)   dir_q   <= (dir_q   & ~bm) | wm;
         if (wr && woff == OFF_IE)    ie_q    <= (ie_q    & ~bm) | wm;
         if (wr && woff == OFF_ITYPE) itype_q <= (itype_q & ~bm) | wm;
         if (wr && woff == OFF_IPOL)  ipol_q  <= (ipol_q  & ~bm) | wm;
      end
   end

   // ---------------- input synchronizer and event detection ----------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q <= '0;
         s_d    <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
         s_d    <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   for (genvar i = 0; i < N_GPIO; i++) begin : g_ev
      assign ev[i] = itype_q[i] ? (ipol_q[i] ? rise[i] : fall[i])
                                : (ipol_q[i] ? s[i]    : ~s[i]);
   end

   // Set dominates clear, so a still-active level source re-arms its bit.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) istat_q <= '0;
      else         istat_q <= (istat_q & ~w1c) | ev;
   end

   // ---------------- bus read path ----------------
   always_comb begin
      rd_mux = '0;
      case (woff)
         OFF_DIR:   rd_mux[N_GPIO-1:0] = dir_q;
         OFF_OUT:   rd_mux[N_GPIO-1:0] = out_q;
         OFF_IN:    rd_mux[N_GPIO-1:0] = s;
         OFF_IE:    rd_mux[N_GPIO-1:0] = ie_q;
         OFF_ITYPE: rd_mux[N_GPIO-1:0] = itype_q;
         OFF_IPOL:  rd_mux[N_GPIO-1:0] = ipol_q;
         OFF_ISTAT: rd_mux[N_GPIO-1:0] = istat_q;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= gnt;
         if (rd) rdata_q <= rd_mux;
      end
   end

   assign data_gnt_o    = gnt;
   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_q;
   assign gpio_o        = out_q;
   assign gpio_oe_o     = dir_q;
   assign irq_o         = |(istat_q & ie_q);

   // Address lane bits and bits above N_GPIO carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{data_addr_i[1:0], data_wdata_i, be_mask};

endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;
   localparam int AW = 12;
   localparam int N  = 16;
   localparam int SS = 2;
   localparam logic [31:0] NMASK = 32'h0000_FFFF;

   logic          clk_i = 0, rstn_i = 0;
   logic          en_i = 0, data_req_i = 0, data_we_i = 0;
   logic [3:0]    data_be_i = 0;
   logic [AW-1:0] data_addr_i = 0;
   logic [31:0]   data_wdata_i = 0;
   logic [N-1:0]  gpio_i = 0;
   logic          data_gnt_o, data_rvalid_o, irq_o;
   logic [31:0]   data_rdata_o;
   logic [N-1:0]  gpio_o, gpio_oe_o;

   gpio_ctrl #(.ADDR_WIDTH(AW), .N_GPIO(N), .SYNC_STAGES(SS)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .data_req_i(data_req_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rdata_o(data_rdata_o), .gpio_i(gpio_i), .gpio_o(gpio_o),
      .gpio_oe_o(gpio_oe_o), .irq_o(irq_o));

   always #5 clk_i = ~clk_i;

   int checks = 0, errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Register contents as plain words; the input path is a history of the
   // pin values seen at each clock edge, newest first.
   logic [31:0] m_dir, m_out, m_ie, m_it, m_ip, m_ist, m_rdata;
   logic [31:0] hist[$];
   int          cyc;
   typedef struct { int cyc; logic [31:0] data; } rsp_t;
   rsp_t sbq[$];

   function automatic logic [31:0] m_read(input logic [AW-1:0] a);
      case (int'(a) & ~3)
         'h00: return m_dir;
         'h04: return m_out;
         'h08: return hist[SS-1];
         'h18: return m_ie;
         'h1C: return m_it;
         'h20: return m_ip;
         'h24: return m_ist;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_dir = 0; m_out = 0; m_ie = 0; m_it = 0; m_ip = 0; m_ist = 0; m_rdata = 0;
      hist = {};
      repeat (SS + 1) hist.push_back(32'h0);
      sbq.delete();
   endtask

   initial begin
      logic [31:0] s, sd, ev, bemask, bm, m, w1c;
      cyc = 0;
      m_reset();
      forever begin
         @(posedge clk_i or negedge rstn_i);
         if (!rstn_i) m_reset();
         else begin
            s  = hist[SS-1];
            sd = hist[SS];
            ev = 0;
            for (int i = 0; i < N; i++)
               ev[i] = m_it[i] ? (m_ip[i] ? (s[i] & ~sd[i]) : (~s[i] & sd[i]))
                               : (m_ip[i] ? s[i] : ~s[i]);
            cyc++;
            w1c = 0;
            if (en_i && data_req_i) begin
               if (!data_we_i) m_rdata = m_read(data_addr_i);
               sbq.push_back('{cyc, m_rdata});
               if (data_we_i) begin
                  bemask = 0;
                  for (int b = 0; b < 4; b++) if (data_be_i[b]) bemask |= 32'hFF << (8*b);
                  bm = bemask & NMASK;
                  m  = data_wdata_i & bm;
                  case (int'(data_addr_i) & ~3)
                     'h00: m_dir = (m_dir & ~bm) | m;
                     'h04: m_out = (m_out & ~bm) | m;
                     'h0C: m_out = m_out | m;
                     'h10: m_out = m_out & ~m;
                     'h14: m_out = m_out ^ m;
                     'h18: m_ie  = (m_ie & ~bm) | m;
                     'h1C: m_it  = (m_it & ~bm) | m;
                     'h20: m_ip  = (m_ip & ~bm) | m;
                     'h24: w1c   = m;
                     default: ;
                  endcase
               end
            end
            m_ist = (m_ist & ~w1c) | ev;
            hist.push_front(32'(gpio_i));
            void'(hist.pop_back());
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk_i);
         if (rstn_i) begin
            check("gpio_o", 32'(gpio_o), m_out);
            check("gpio_oe_o", 32'(gpio_oe_o), m_dir);
            check("irq_o", 32'(irq_o), 32'(|(m_ist & m_ie)));
            if (data_rvalid_o) begin
               if (sbq.size() == 0) check("rvalid_spurious", 32'(data_rvalid_o), 32'h0);
               else begin
                  r = sbq.pop_front();
                  check("rvalid_cycle", cyc, r.cyc);
                  check("rdata", data_rdata_o, r.data);
               end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
               r = sbq.pop_front();
               check("rvalid_missing", 32'(data_rvalid_o), 32'h1);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic bus(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] be);
      @(negedge clk_i);
      en_i = 1; data_req_i = 1; data_we_i = we;
      data_addr_i = a; data_wdata_i = d; data_be_i = be;
      #1 check("gnt", 32'(data_gnt_o), 32'h1);
      @(negedge clk_i);
      en_i = 0; data_req_i = 0; data_we_i = 0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      bus(1'b1, a, d, 4'hF);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      bus(1'b0, a, 32'h0, 4'hF);
   endtask

   initial begin
      #2;
      check("rst_gpio_o", 32'(gpio_o), 0);
      check("rst_oe", 32'(gpio_oe_o), 0);
      check("rst_irq", 32'(irq_o), 0);
      check("rst_rvalid", 32'(data_rvalid_o), 0);
      check("rst_rdata", data_rdata_o, 0);
      repeat (3) @(negedge clk_i);
      rstn_i = 1;

      for (int a = 0; a <= 'h2C; a += 4) rd(AW'(a));
      rd(AW'('h0A));
      rd(AW'('h100));
      check("rd_dir0", data_rdata_o, 0);

      wr('h00, 32'h00FF);
      wr('h04, 32'h1234);
      wr('h0C, 32'h0001);
      wr('h10, 32'h0200);
      wr('h14, 32'h8000);
      check("out_atomic", 32'(gpio_o), 32'h9035);
      check("dir_ff", 32'(gpio_oe_o), 32'h00FF);

      wr('h04, 32'h0);
      bus(1'b1, 'h04, 32'hFFFF, 4'b0001);
      check("out_be", 32'(gpio_o), 32'h00FF);
      wr('h00, 32'hFFFF_FFFF);
      rd('h00);
      check("dir_upper", data_rdata_o, 32'h0000_FFFF);

      // Rising-edge detection on pin 0.
      wr('h1C, 32'hFFFF);
      wr('h20, 32'hFFFF);
      wr('h24, 32'hFFFF);
      wr('h18, 32'h0001);
      rd('h24);
      check("istat_clr", data_rdata_o, 0);
      gpio_i[0] = 1;
      @(negedge clk_i);
      @(negedge clk_i);
      check("irq_edge2", 32'(irq_o), 0);
      @(negedge clk_i);
      check("irq_edge3", 32'(irq_o), 1);
      wr('h24, 32'h1);
      check("irq_w1c", 32'(irq_o), 0);
      gpio_i[0] = 0;
      repeat (5) @(negedge clk_i);
      check("irq_fall", 32'(irq_o), 0);

      // Level-low on pin 3 overrides W1C while active.
      wr('h1C, 32'hFFF7);
      wr('h20, 32'hFFF7);
      wr('h18, 32'h0008);
      wr('h24, 32'h0008);
      rd('h24);
      check("lvl_stick", data_rdata_o, 32'h8);
      check("lvl_irq", 32'(irq_o), 1);
      gpio_i[3] = 1;
      repeat (SS + 2) @(negedge clk_i);
      wr('h24, 32'h0008);
      rd('h24);
      check("lvl_clr", data_rdata_o, 0);
      check("lvl_irq0", 32'(irq_o), 0);

      // Rising event on pin 5 at the same edge as its W1C.
      @(negedge clk_i);
      gpio_i[5] = 1;
      @(negedge clk_i);
      wr('h24, 32'h0020);
      rd('h24);
      check("set_wins", data_rdata_o, 32'h20);

      // Randomized back-to-back traffic with pin activity.
      repeat (2000) begin
         @(negedge clk_i);
         en_i         = ($urandom % 4) != 0;
         data_req_i   = $urandom % 2;
         data_we_i    = $urandom % 2;
         data_addr_i  = AW'(($urandom_range(0, 11) * 4) | ($urandom % 4));
         data_be_i    = 4'($urandom);
         data_wdata_i = $urandom;
         if ($urandom % 4 == 0) gpio_i = gpio_i ^ N'(1 << $urandom_range(0, N - 1));
      end
      @(negedge clk_i);
      en_i = 0; data_req_i = 0; data_we_i = 0;
      repeat (3) @(negedge clk_i);

      // Reset while a response is pending.
      wr('h04, 32'h5555);
      @(negedge clk_i);
      en_i = 1; data_req_i = 1; data_we_i = 0; data_addr_i = 'h04;
      @(posedge clk_i);
      #1;
      en_i = 0; data_req_i = 0;
      check("pend_rvalid", 32'(data_rvalid_o), 1);
      rstn_i = 0;
      #1;
      check("rst_mid_rvalid", 32'(data_rvalid_o), 0);
      check("rst_mid_rdata", data_rdata_o, 0);
      check("rst_mid_out", 32'(gpio_o), 0);
      repeat (2) @(negedge clk_i);
      rstn_i = 1;
      repeat (3) @(negedge clk_i);
      check("queue_drain", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
